// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, load/store port, stall and RAM-side signals of the memory arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface mem_arbiter_if #(
   parameter int AW = 10
);
   logic          if_req;
   logic [31:0]   if_addr;
   logic [31:0]   if_rdata;
   logic          if_ready;
   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ready;
   logic          stall;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
      output if_rdata, if_ready, mem_rdata, mem_ready, stall, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
      input  if_rdata, if_ready, mem_rdata, mem_ready, stall, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store ports.
// One access in flight at a time; alternating grant under contention; stall while a request is pending.
module mem_arbiter #(
   parameter int AW  = 10,
   parameter int LAT = 1
) (
   input logic          clka,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last_mem_q, last_mem_d;   // 0 = FETCH was granted last
   logic          gnt_mem_q, gnt_mem_d;
   logic          is_st_q, is_st_d;
   logic          ram_en_q, ram_en_d;
   logic [3:0]    ram_we_q, ram_we_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]   ram_wdata_q, ram_wdata_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   mem_rdata_q, mem_rdata_d;
   logic          if_ready_q, if_ready_d;
   logic          mem_ready_q, mem_ready_d;

   // byte offset and bits above the RAM window are deliberately dropped
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[31:AW+2], bus.if_addr[1:0],
                               bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_mem_q  <= 1'b0;
         gnt_mem_q   <= 1'b0;
         is_st_q     <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_mem_q  <= last_mem_d;
         gnt_mem_q   <= gnt_mem_d;
         is_st_q     <= is_st_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_mem_d  = last_mem_q;
      gnt_mem_d   = gnt_mem_q;
      is_st_d     = is_st_q;
      ram_en_d    = ram_en_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = if_ready_q;
      mem_ready_d = mem_ready_q;
      case (state_q)
         IDLE: begin
            if (bus.mem_req && (!bus.if_req || !last_mem_q)) begin
               gnt_mem_d  = 1'b1;
               last_mem_d = 1'b1;
               is_st_d    = bus.mem_we;
               ram_en_d   = 1'b1;
               ram_addr_d = bus.mem_addr[AW+1:2];
               ram_we_d   = bus.mem_we ? bus.mem_be : 4'b0000;
               if (bus.mem_we) ram_wdata_d = bus.mem_wdata;
               state_d    = ISSUE;
            end else if (bus.if_req) begin
               gnt_mem_d  = 1'b0;
               last_mem_d = 1'b0;
               is_st_d    = 1'b0;
               ram_en_d   = 1'b1;
               ram_addr_d = bus.if_addr[AW+1:2];
               ram_we_d   = 4'b0000;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            ram_en_d = 1'b0;
            ram_we_d = 4'b0000;
            cnt_d    = 4'(LAT - 1);
            state_d  = WAIT;
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (gnt_mem_q) begin
                  if (!is_st_q) mem_rdata_d = bus.ram_rdata;
                  mem_ready_d = 1'b1;
               end else begin
                  if_rdata_d = bus.ram_rdata;
                  if_ready_d = 1'b1;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if_ready_d  = 1'b0;
            mem_ready_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ram_en    = ram_en_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.mem_ready = mem_ready_q;
   assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.mem_req & ~mem_ready_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=1 instance with vector table and corner sequences, LAT=3 instance for latency.
module tb_mem_arbiter;
   localparam int AW = 10;

   logic clka;
   logic rst;

   mem_arbiter_if #(.AW(AW)) b1();
   mem_arbiter_if #(.AW(AW)) b3();

   mem_arbiter #(.AW(AW), .LAT(1)) u1 (.clka(clka), .rst(rst), .bus(b1));
   mem_arbiter #(.AW(AW), .LAT(3)) u3 (.clka(clka), .rst(rst), .bus(b3));

   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   // RAM models: garbage on idle cycles so a mistimed capture is visible
   logic [31:0] ram1 [0:1023];
   logic [31:0] ram3 [0:1023];
   logic [31:0] p1, p3_0, p3_1, p3_2;
   bit          init_done = 1'b0;

   always @(posedge clka) begin
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) begin
            ram1[i] <= 32'h0;
            ram3[i] <= 32'h0;
         end
         ram1[2]     <= 32'h1122_3344;
         ram1[4]     <= 32'h2010_0005;
         ram1[7]     <= 32'h0BAD_C0DE;
         ram1[10'h3FF] <= 32'hCAFE_F00D;
         ram3[5]     <= 32'h3333_5555;
         p1 <= 32'hDEAD_BEEF; p3_0 <= 32'hDEAD_BEEF; p3_1 <= 32'hDEAD_BEEF; p3_2 <= 32'hDEAD_BEEF;
         init_done <= 1'b1;
      end else begin
         p1 <= b1.ram_en ? ram1[b1.ram_addr] : 32'hDEAD_BEEF;
         if (b1.ram_en)
            for (int i = 0; i < 4; i++)
               if (b1.ram_we[i]) ram1[b1.ram_addr][8*i +: 8] <= b1.ram_wdata[8*i +: 8];
         p3_0 <= b3.ram_en ? ram3[b3.ram_addr] : 32'hDEAD_BEEF;
         p3_1 <= p3_0;
         p3_2 <= p3_1;
         if (b3.ram_en)
            for (int i = 0; i < 4; i++)
               if (b3.ram_we[i]) ram3[b3.ram_addr][8*i +: 8] <= b3.ram_wdata[8*i +: 8];
      end
   end
   assign b1.ram_rdata = p1;
   assign b3.ram_rdata = p3_2;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One access on the LAT=1 instance; starts and ends one time unit after a rising edge, in IDLE.
   task automatic run1(input bit m, input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input bit scr, output logic [31:0] rd, output int lat,
                       output logic [AW-1:0] ra, output logic [3:0] rwe, output bit stall_ok);
      int acc;
      acc = -1; lat = -1; ra = '0; rwe = '0; stall_ok = 1'b1;
      if (m) begin
         b1.mem_we = we; b1.mem_be = be; b1.mem_addr = addr; b1.mem_wdata = wd; b1.mem_req = 1'b1;
      end else begin
         b1.if_addr = addr; b1.if_req = 1'b1;
      end
      #1;
      if (!b1.stall) stall_ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clka); #1;
         if (b1.ram_en) begin
            acc = c; ra = b1.ram_addr; rwe = b1.ram_we;
            if (scr) begin
               b1.mem_addr = 32'h24; b1.mem_wdata = 32'hFFFF_FFFF; b1.mem_we = 1'b0; b1.mem_be = 4'h0;
            end
         end
         if (m ? b1.mem_ready : b1.if_ready) begin
            lat = c - acc;
            if (b1.stall) stall_ok = 1'b0;
            break;
         end else if (!b1.stall) stall_ok = 1'b0;
      end
      rd = m ? b1.mem_rdata : b1.if_rdata;
      @(posedge clka); #1;
      b1.mem_req = 1'b0; b1.if_req = 1'b0;
   endtask

   // Both ports request continuously until three accesses complete.
   task automatic contend(output logic [AW-1:0] first_ra, output logic [2:0] order,
                          output int gap1, output int gap2, output bit adj, output bit to);
      int acc [3];
      int na, nr;
      bit prev_en;
      na = 0; nr = 0; prev_en = 1'b0; adj = 1'b0; to = 1'b1; order = '0; first_ra = '0;
      acc[0] = 0; acc[1] = 0; acc[2] = 0;
      b1.mem_we = 1'b0; b1.mem_addr = 32'h8; b1.if_addr = 32'h10;
      b1.mem_req = 1'b1; b1.if_req = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clka); #1;
         if (b1.ram_en && prev_en) adj = 1'b1;
         prev_en = b1.ram_en;
         if (b1.ram_en && na < 3) begin
            if (na == 0) first_ra = b1.ram_addr;
            acc[na] = c; na++;
         end
         if (b1.mem_ready) begin order[nr] = 1'b1; nr++; end
         else if (b1.if_ready) begin order[nr] = 1'b0; nr++; end
         if (nr == 3) begin to = 1'b0; break; end
      end
      gap1 = acc[1] - acc[0];
      gap2 = acc[2] - acc[1];
      b1.mem_req = 1'b0; b1.if_req = 1'b0;
      @(posedge clka); #1;
   endtask

   typedef struct {
      bit            m;
      bit            we;
      logic [3:0]    be;
      logic [31:0]   addr;
      logic [31:0]   wd;
      logic [31:0]   exp_rd;
      logic [AW-1:0] exp_ra;
      logic [3:0]    exp_we;
   } vec_t;

   vec_t vt [9];

   initial begin
      logic [31:0]   rd;
      logic [AW-1:0] ra, fra;
      logic [3:0]    rwe;
      logic [2:0]    order;
      int            lat, g1, g2, acc3, lat3;
      bit            sok, adj, to, got, seen;

      // m, we, be, addr, wdata, expected rdata, expected ram_addr, expected ram_we
      vt[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,          32'h2010_0005, 10'd4,   4'h0};
      vt[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0008, 32'hAABB_CCDD, 32'h1122_3344, 10'd2,   4'h3};
      vt[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0,          32'h1122_CCDD, 10'd2,   4'h0};
      vt[3] = '{1'b1, 1'b0, 4'h0, 32'h0000_0FFF, 32'h0,          32'hCAFE_F00D, 10'h3FF, 4'h0};
      vt[4] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_F01F, 32'h0,          32'h0BAD_C0DE, 10'd7,   4'h0};
      vt[5] = '{1'b1, 1'b1, 4'hF, 32'h0000_001C, 32'h1111_1111, 32'hCAFE_F00D, 10'd7,   4'hF};
      vt[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_001C, 32'h0,          32'h1111_1111, 10'd7,   4'h0};
      vt[7] = '{1'b1, 1'b1, 4'h8, 32'h0000_0010, 32'h9900_0000, 32'hCAFE_F00D, 10'd4,   4'h8};
      vt[8] = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,          32'h9910_0005, 10'd4,   4'h0};

      rst = 1'b0;
      b1.if_req = 1'b0; b1.if_addr = '0; b1.mem_req = 1'b0; b1.mem_we = 1'b0;
      b1.mem_be = '0; b1.mem_addr = '0; b1.mem_wdata = '0;
      b3.if_req = 1'b0; b3.if_addr = '0; b3.mem_req = 1'b0; b3.mem_we = 1'b0;
      b3.mem_be = '0; b3.mem_addr = '0; b3.mem_wdata = '0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clka);
      #1;
      chk("rst_ram_en",    64'(b1.ram_en),    64'd0);
      chk("rst_ram_we",    64'(b1.ram_we),    64'd0);
      chk("rst_ram_addr",  64'(b1.ram_addr),  64'd0);
      chk("rst_ram_wdata", 64'(b1.ram_wdata), 64'd0);
      chk("rst_if_rdata",  64'(b1.if_rdata),  64'd0);
      chk("rst_mem_rdata", 64'(b1.mem_rdata), 64'd0);
      chk("rst_readys",    64'({b1.if_ready, b1.mem_ready}), 64'd0);
      chk("rst_stall",     64'(b1.stall),     64'd0);
      chk("rst_l3_ram_en", 64'(b3.ram_en),    64'd0);
      @(negedge clka) rst = 1'b0;
      @(posedge clka); #1;

      // contention straight out of reset: data wins first, then alternation
      contend(fra, order, g1, g2, adj, to);
      chk("cont_timeout",  64'(to),    64'd0);
      chk("cont_first_ra", 64'(fra),   64'd2);
      chk("cont_order",    64'(order), 64'b101);
      chk("cont_gap1",     64'(g1),    64'd4);
      chk("cont_gap2",     64'(g2),    64'd4);
      chk("cont_adjacent", 64'(adj),   64'd0);
      chk("cont_if_rdata", 64'(b1.if_rdata),  64'h2010_0005);
      chk("cont_mem_rdata",64'(b1.mem_rdata), 64'h1122_3344);

      for (int i = 0; i < 9; i++) begin
         run1(vt[i].m, vt[i].we, vt[i].be, vt[i].addr, vt[i].wd, 1'b0, rd, lat, ra, rwe, sok);
         chk($sformatf("v%0d_rdata", i),    64'(rd),  64'(vt[i].exp_rd));
         chk($sformatf("v%0d_latency", i),  64'(lat), 64'd2);
         chk($sformatf("v%0d_ram_addr", i), 64'(ra),  64'(vt[i].exp_ra));
         chk($sformatf("v%0d_ram_we", i),   64'(rwe), 64'(vt[i].exp_we));
         chk($sformatf("v%0d_stall", i),    64'(sok), 64'd1);
      end

      repeat (3) @(posedge clka);
      #1;
      chk("hold_if_rdata",  64'(b1.if_rdata),  64'h1111_1111);
      chk("hold_mem_rdata", 64'(b1.mem_rdata), 64'h9910_0005);

      // inputs changed right after acceptance must not reach the RAM
      run1(1'b1, 1'b1, 4'hF, 32'h20, 32'h5555_AAAA, 1'b1, rd, lat, ra, rwe, sok);
      chk("scr_ram_addr",  64'(ra),       64'd8);
      chk("scr_ram_we",    64'(rwe),      64'hF);
      chk("scr_mem_rdata", 64'(rd),       64'h9910_0005);
      chk("scr_word8",     64'(ram1[8]),  64'h5555_AAAA);
      chk("scr_word9",     64'(ram1[9]),  64'h0);
      run1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, rd, lat, ra, rwe, sok);
      chk("scr_reload",    64'(rd),       64'h5555_AAAA);

      // LAT=3 load
      acc3 = -1; lat3 = -1;
      b3.mem_we = 1'b0; b3.mem_addr = 32'h14; b3.mem_req = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clka); #1;
         if (b3.ram_en) acc3 = c;
         if (b3.mem_ready) begin lat3 = c - acc3; break; end
      end
      chk("l3_latency", 64'(lat3),         64'd4);
      chk("l3_rdata",   64'(b3.mem_rdata), 64'h3333_5555);
      @(posedge clka); #1;
      b3.mem_req = 1'b0;

      // reset while a load waits on the RAM
      got = 1'b0;
      b1.mem_we = 1'b0; b1.mem_addr = 32'h10; b1.mem_req = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clka); #1;
         if (b1.ram_en) begin got = 1'b1; break; end
      end
      chk("rw_accept", 64'(got), 64'd1);
      @(posedge clka); #2;
      rst = 1'b1; b1.mem_req = 1'b0;
      #1;
      chk("rw_ram",    64'({b1.ram_en, b1.ram_we, b1.ram_addr}), 64'd0);
      chk("rw_wdata",  64'(b1.ram_wdata), 64'd0);
      chk("rw_rdata",  64'({b1.if_rdata, b1.mem_rdata}), 64'd0);
      chk("rw_readys", 64'({b1.if_ready, b1.mem_ready}), 64'd0);
      #1 rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clka); #1;
         if (b1.if_ready || b1.mem_ready) seen = 1'b1;
      end
      chk("rw_no_ready",   64'(seen),         64'd0);
      chk("rw_mem_rdata",  64'(b1.mem_rdata), 64'd0);
      contend(fra, order, g1, g2, adj, to);
      chk("rw_timeout",    64'(to),    64'd0);
      chk("rw_first_ra",   64'(fra),   64'd2);
      chk("rw_order",      64'(order), 64'b101);
      chk("rw_if_rdata",   64'(b1.if_rdata),  64'h9910_0005);
      chk("rw_mem_rdata2", 64'(b1.mem_rdata), 64'h1122_CCDD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
